// File: rtl/vid_pkg.sv
// Shared constants and types for the video RAM display-side fetch path.
package vid_pkg;

  localparam int VRAM_AW = 15;
  localparam int VRAM_DW = 8;
  localparam int RD_LAT  = 2;

  localparam logic [VRAM_DW-1:0] BLANK_CODE = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/vid_line_buf.sv
// One text row of character codes: single write port, registered read port
// that substitutes the blank code for columns past the end of the row.
module vid_line_buf
  import vid_pkg::*;
#(
  parameter int DEPTH = 80,
  parameter int AW    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [VRAM_DW-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  input  logic               rd_blank,
  output logic [VRAM_DW-1:0] rd_data
);

  logic [VRAM_DW-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < AW'(DEPTH))) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)         rd_data <= '0;
    else if (rd_blank) rd_data <= BLANK_CODE;
    else               rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vram_scan_fetch.sv
// Display-side VRAM reader: copies one text row into a line buffer during
// hblank and serves character codes plus scanline to the character generator.
module vram_scan_fetch #(
  parameter int COLS_MAX   = 80,
  parameter int CHAR_H_MAX = 16,
  parameter int ROWS_MAX   = 32,
  parameter int RD_LAT     = vid_pkg::RD_LAT,
  localparam int COL_W     = $clog2(COLS_MAX),
  localparam int SCAN_W    = $clog2(CHAR_H_MAX),
  localparam int CROW_W    = $clog2(ROWS_MAX)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        line_start,
  input  logic [vid_pkg::VRAM_AW-1:0] cfg_base,
  input  logic [COL_W-1:0]            cfg_cols,
  input  logic [CROW_W-1:0]           cfg_rows,
  input  logic [SCAN_W-1:0]           cfg_char_h,
  output logic [vid_pkg::VRAM_AW-1:0] vram_adb,
  output logic                        vram_ceb,
  output logic                        vram_oceb,
  input  logic [vid_pkg::VRAM_DW-1:0] vram_doutb,
  input  logic [COL_W-1:0]            disp_col,
  output logic [vid_pkg::VRAM_DW-1:0] disp_char,
  output logic [SCAN_W-1:0]           disp_scan,
  output logic                        disp_blank,
  output logic                        busy,
  output logic                        fetch_done,
  output logic                        err_overrun
);

  import vid_pkg::*;

  localparam int ROW_W = $clog2(ROWS_MAX + 1);
  localparam logic [RD_LAT-1:0] LOWER_MASK = {RD_LAT{1'b1}} >> 1;

  typedef struct packed {
    logic             valid;
    logic [COL_W-1:0] col;
  } ret_slot_t;

  fetch_state_e       state;
  logic [ROW_W-1:0]   row;
  logic [SCAN_W-1:0]  scan;
  logic [VRAM_AW-1:0] row_base;
  logic [COL_W-1:0]   fetch_cols;
  logic [COL_W-1:0]   issue_col;
  ret_slot_t          ret_pipe [RD_LAT];

  logic [ROW_W-1:0]   row_eff;
  logic [SCAN_W-1:0]  scan_eff;
  logic [VRAM_AW-1:0] base_eff;
  logic [CROW_W-1:0]  rows_last;
  logic               busy_eff;
  logic               row_blank;
  logic               launch;
  logic [RD_LAT-1:0]  ret_valid;
  logic               buf_wr_en;
  logic               rd_blank;

  assign vram_oceb = 1'b1;

  // frame_start is folded in first so a coincident line_start sees cleared counters.
  // NOTE: every always_comb output gets a default before any branch, so no latch.
  always_comb begin
    row_eff   = frame_start ? '0 : row;
    scan_eff  = frame_start ? '0 : scan;
    base_eff  = frame_start ? cfg_base : row_base;
    busy_eff  = busy & ~frame_start;
    rows_last = cfg_rows - 1'b1;
    row_blank = row_eff > ROW_W'(rows_last);
    launch    = line_start & ~row_blank & (scan_eff == '0) & ~busy_eff;
    ret_valid = '0;
    for (int i = 0; i < RD_LAT; i++) ret_valid[i] = ret_pipe[i].valid;
    buf_wr_en = ret_pipe[RD_LAT-1].valid & ~frame_start;
    rd_blank  = (disp_col >= cfg_cols) | (disp_col >= COL_W'(COLS_MAX));
  end

  // Later non-blocking assignments override earlier ones: abort, then launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      row         <= '0;
      scan        <= '0;
      row_base    <= '0;
      fetch_cols  <= '0;
      issue_col   <= '0;
      vram_adb    <= '0;
      vram_ceb    <= 1'b0;
      busy        <= 1'b0;
      fetch_done  <= 1'b0;
      err_overrun <= 1'b0;
      disp_scan   <= '0;
      disp_blank  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) ret_pipe[i] <= '0;
    end else begin
      fetch_done <= 1'b0;
      if (fetch_done) busy <= 1'b0;

      for (int i = RD_LAT - 1; i > 0; i--) ret_pipe[i] <= ret_pipe[i-1];
      ret_pipe[0] <= '{valid: (state == ISSUE), col: issue_col};

      case (state)
        ISSUE: begin
          if (issue_col == fetch_cols - 1'b1) begin
            state    <= DRAIN;
            vram_ceb <= 1'b0;
          end else begin
            issue_col <= issue_col + 1'b1;
            vram_adb  <= vram_adb + 1'b1;
          end
        end
        DRAIN: begin
          // Done once only the oldest slot, written on this edge, is still valid.
          if ((ret_valid & LOWER_MASK) == '0) begin
            state      <= IDLE;
            fetch_done <= 1'b1;
          end
        end
        default: ;
      endcase

      if (frame_start) begin
        state      <= IDLE;
        vram_ceb   <= 1'b0;
        busy       <= 1'b0;
        fetch_done <= 1'b0;
        row        <= '0;
        scan       <= '0;
        row_base   <= cfg_base;
        for (int i = 0; i < RD_LAT; i++) ret_pipe[i].valid <= 1'b0;
      end

      if (line_start) begin
        disp_scan  <= scan_eff;
        disp_blank <= row_blank;
        if (busy_eff) err_overrun <= 1'b1;
        if (launch) begin
          state      <= ISSUE;
          vram_ceb   <= 1'b1;
          vram_adb   <= base_eff;
          issue_col  <= '0;
          fetch_cols <= cfg_cols;
          busy       <= 1'b1;
        end
        if (scan_eff == cfg_char_h) begin
          scan     <= '0;
          row      <= (row_eff == ROW_W'(ROWS_MAX)) ? row_eff : row_eff + 1'b1;
          row_base <= base_eff + VRAM_AW'(cfg_cols);
        end else begin
          scan <= scan_eff + 1'b1;
        end
      end
    end
  end

  vid_line_buf #(
    .DEPTH (COLS_MAX),
    .AW    (COL_W)
  ) u_line_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (buf_wr_en),
    .wr_addr  (ret_pipe[RD_LAT-1].col),
    .wr_data  (vram_doutb),
    .rd_addr  (disp_col),
    .rd_blank (rd_blank),
    .rd_data  (disp_char)
  );

endmodule

// File: tb/tb_vram_scan_fetch.sv
// Self-checking bench for vram_scan_fetch: VRAM model, address scoreboard,
// row/scan reference model and table-driven display reads.
module tb_vram_scan_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, frame_start, line_start;
  logic [14:0] cfg_base;
  logic [6:0]  cfg_cols;
  logic [4:0]  cfg_rows;
  logic [3:0]  cfg_char_h;
  logic [14:0] vram_adb;
  logic        vram_ceb, vram_oceb;
  logic [7:0]  vram_doutb;
  logic [6:0]  disp_col;
  logic [7:0]  disp_char;
  logic [3:0]  disp_scan;
  logic        disp_blank, busy, fetch_done, err_overrun;

  vram_scan_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .cfg_base    (cfg_base),
    .cfg_cols    (cfg_cols),
    .cfg_rows    (cfg_rows),
    .cfg_char_h  (cfg_char_h),
    .vram_adb    (vram_adb),
    .vram_ceb    (vram_ceb),
    .vram_oceb   (vram_oceb),
    .vram_doutb  (vram_doutb),
    .disp_col    (disp_col),
    .disp_char   (disp_char),
    .disp_scan   (disp_scan),
    .disp_blank  (disp_blank),
    .busy        (busy),
    .fetch_done  (fetch_done),
    .err_overrun (err_overrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int issue_count = 0;
  logic [14:0] addr_q [$];

  int          m_row, m_scan;
  logic [14:0] m_base;
  bit          m_busy, m_ovr;
  int          launch_cyc;

  typedef struct {
    logic [6:0] col;
    logic [7:0] exp;
  } disp_vec_t;
  disp_vec_t vecs [$];

  function automatic logic [7:0] vram_val(input logic [14:0] a);
    return a[7:0] ^ {a[14:8], 1'b0} ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Port-B model: registered address stage plus output register.
  logic [7:0] rd_s1 = '0;
  logic [7:0] rd_s2 = '0;
  always @(posedge clk) begin
    if (vram_ceb) rd_s1 <= vram_val(vram_adb);
    rd_s2 <= rd_s1;
  end
  assign vram_doutb = rd_s2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fetch_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
    if (vram_ceb) begin
      issue_count++;
      check("issue_expected", addr_q.size() != 0, 1);
      if (addr_q.size() != 0) check("vram_adb", vram_adb, addr_q.pop_front());
    end
  end

  task automatic do_line(input bit fs, input bit ls);
    bit exp_launch;
    bit exp_blank;
    int exp_scan;
    @(posedge clk); #1;
    frame_start = fs;
    line_start  = ls;
    @(posedge clk); #1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    if (fs) begin
      m_row = 0; m_scan = 0; m_base = cfg_base; m_busy = 0;
      addr_q.delete();
    end
    if (ls) begin
      exp_scan   = m_scan;
      exp_blank  = (m_row > int'(cfg_rows) - 1);
      exp_launch = !m_busy && !exp_blank && (m_scan == 0);
      if (m_busy) m_ovr = 1;
      if (exp_launch) begin
        for (int i = 0; i < int'(cfg_cols); i++) addr_q.push_back(m_base + 15'(i));
        m_busy = 1;
        launch_cyc = cyc;
      end
      if (m_scan == int'(cfg_char_h)) begin
        m_scan = 0;
        if (m_row < 32) m_row++;
        m_base = m_base + 15'(cfg_cols);
      end else begin
        m_scan++;
      end
      check("disp_scan", disp_scan, exp_scan);
      check("disp_blank", disp_blank, exp_blank);
      check("err_overrun", err_overrun, m_ovr);
      if (exp_launch) check("busy_after_launch", busy, 1);
    end
  endtask

  task automatic wait_fetch(input int cols);
    int start;
    int n;
    start = fd_count;
    n = 0;
    while (fd_count == start && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("fetch_done_seen", fd_count - start, 1);
    check("fetch_latency", fd_cyc - launch_cyc, cols + 2);
    check("all_addrs_issued", addr_q.size(), 0);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    m_busy = 0;
  endtask

  task automatic run_disp(input string tag);
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      disp_col = vecs[i].col;
      @(posedge clk); #1;
      check($sformatf("%s_disp_char_col%0d", tag, vecs[i].col), disp_char, vecs[i].exp);
    end
    vecs.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int ic;
    int fd0;
    reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
    cfg_base = 15'h3C00; cfg_cols = 7'd64; cfg_rows = 5'd16; cfg_char_h = 4'd11;
    disp_col = '0;
    m_row = 0; m_scan = 0; m_base = '0; m_busy = 0; m_ovr = 0; launch_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vram_adb", vram_adb, 0);
    check("rst_vram_ceb", vram_ceb, 0);
    check("rst_vram_oceb", vram_oceb, 1);
    check("rst_disp_char", disp_char, 0);
    check("rst_disp_scan", disp_scan, 0);
    check("rst_disp_blank", disp_blank, 0);
    check("rst_busy", busy, 0);
    check("rst_fetch_done", fetch_done, 0);
    check("rst_err_overrun", err_overrun, 0);
    reset = 1'b0;

    // First row fetch from 0x3C00, 64 columns.
    do_line(1, 1);
    wait_fetch(64);
    vecs.push_back('{7'd5,   vram_val(15'h3C05)});
    vecs.push_back('{7'd0,   vram_val(15'h3C00)});
    vecs.push_back('{7'd63,  vram_val(15'h3C3F)});
    vecs.push_back('{7'd64,  8'h20});
    vecs.push_back('{7'd100, 8'h20});
    run_disp("row0");

    // Scanlines 1..11 of row 0: no fetch.
    ic = issue_count;
    for (int i = 1; i <= 11; i++) do_line(0, 1);
    check("no_issue_scans_1_11", issue_count, ic);

    // Row 1 fetch from 0x3C40, with a line_start 10 cycles into it.
    do_line(0, 1);
    repeat (9) @(posedge clk);
    do_line(0, 1);
    wait_fetch(64);
    check("overrun_sticky", err_overrun, 1);
    do_line(0, 1);
    vecs.push_back('{7'd0, vram_val(15'h3C40)});
    vecs.push_back('{7'd7, vram_val(15'h3C47)});
    run_disp("row1");

    // Address wrap at the top of VRAM.
    cfg_base = 15'h7FF0; cfg_cols = 7'd32;
    do_line(1, 1);
    wait_fetch(32);
    vecs.push_back('{7'd15, vram_val(15'h7FFF)});
    vecs.push_back('{7'd16, vram_val(15'h0000)});
    vecs.push_back('{7'd31, vram_val(15'h000F)});
    vecs.push_back('{7'd32, 8'h20});
    run_disp("wrap");

    // frame_start alone in mid-ISSUE at col 20.
    cfg_base = 15'h1234; cfg_cols = 7'd40;
    do_line(1, 1);
    repeat (20) @(posedge clk);
    do_line(1, 0);
    check("abort_ceb_low", vram_ceb, 0);
    check("abort_busy_low", busy, 0);
    ic = issue_count;
    fd0 = fd_count;
    repeat (50) @(negedge clk);
    check("abort_no_fetch_done", fd_count, fd0);
    check("abort_no_issue", issue_count, ic);

    // frame_start + line_start in mid-ISSUE: restart row 0 from the new base.
    do_line(0, 1);
    repeat (20) @(posedge clk);
    cfg_base = 15'h0555;
    do_line(1, 1);
    wait_fetch(40);
    vecs.push_back('{7'd0,  vram_val(15'h0555)});
    vecs.push_back('{7'd39, vram_val(15'h057C)});
    run_disp("restart");

    // Reset in mid-DRAIN.
    do_line(1, 1);
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_row = 0; m_scan = 0; m_base = '0; m_busy = 0; m_ovr = 0;
    addr_q.delete();
    check("drain_rst_busy", busy, 0);
    check("drain_rst_ceb", vram_ceb, 0);
    check("drain_rst_overrun", err_overrun, 0);
    check("drain_rst_disp_scan", disp_scan, 0);
    fd0 = fd_count;
    repeat (10) @(negedge clk);
    check("drain_rst_no_fetch_done", fd_count, fd0);

    // Two text rows, one scanline each: third row is blank.
    cfg_rows = 5'd2; cfg_char_h = 4'd0; cfg_cols = 7'd8; cfg_base = 15'h0100;
    do_line(1, 1);
    wait_fetch(8);
    do_line(0, 1);
    wait_fetch(8);
    vecs.push_back('{7'd3, vram_val(15'h010B)});
    vecs.push_back('{7'd8, 8'h20});
    run_disp("rows2");
    ic = issue_count;
    do_line(0, 1);
    do_line(0, 1);
    repeat (20) @(negedge clk);
    check("blank_no_issue", issue_count, ic);
    check("blank_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
